mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit, directly upstream of the MEM/WB register.
//  - Consumes EX/MEM control, address (ex_mem_ALU_out) and store data.
//  - Drives a req/ack data-memory port with a variable number of wait cycles.
//  - Formats load data (byte/half/word, sign/zero extended) into read_data for MEM/WB.
//  - Asserts stall to freeze the pipeline while a memory access is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  255  wait cycles without dmem_ack before the access is aborted with bus_err
//  CNT_W           8    width of the wait counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk                 in   1   pipeline clock; the FSM updates on posedge
//  rst_n               in   1   asynchronous active-low reset
//  ex_mem_MemRead      in   1   load in MEM stage
//  ex_mem_MemWrite     in   1   store in MEM stage; wins if both MemRead and MemWrite are set
//  ex_mem_funct3       in   3   000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//  ex_mem_ALU_out      in   32  effective byte address
//  ex_mem_write_data   in   32  store data, right-aligned
//  dmem_req            out  1   memory request, registered
//  dmem_we             out  1   1 = write
//  dmem_addr           out  32  word address: {addr[31:2],2'b00}
//  dmem_be             out  4   byte enables
//  dmem_wdata          out  32  store data replicated across byte lanes
//  dmem_ack            in   1   completes the request in the cycle it is sampled high with dmem_req
//  dmem_rdata          in   32  read word, valid with dmem_ack
//  read_data           out  32  formatted load result, registered
//  stall               out  1   high = hold the PC, IF/ID, ID/EX and EX/MEM registers
//  misalign_err        out  1   1-cycle pulse: misaligned address or illegal funct3
//  bus_err             out  1   1-cycle pulse: timeout abort
// BEHAVIOUR
//  Reset (asynchronous, rst_n=0)
//  - state=IDLE; every output is 0, including read_data, dmem_addr, dmem_be, dmem_wdata.
//  - dmem_req drops immediately, even mid-access; a late dmem_ack arriving in IDLE is ignored.
//  State machine: IDLE -> ACCESS -> DONE -> IDLE
//  - IDLE: when op = MemRead|MemWrite is present:
//    - stall=1 combinationally.
//    - If aligned and legal: register addr/be/wdata/we, set dmem_req=1, go to ACCESS.
//    - If misaligned (half with addr[0]=1, word with addr[1:0]!=0) or funct3 is 011/110/111:
//      no request; misalign_err=1 for one cycle; read_data=0; stall=0; stay in IDLE.
//  - ACCESS: stall=1; all dmem_* outputs are held stable.
//    - On dmem_ack: dmem_req falls at the next edge; for a load, read_data <= format(dmem_rdata);
//      go to DONE.
//    - The wait counter increments each cycle without ack; when it reaches TIMEOUT_CYCLES:
//      abort, bus_err=1, read_data=0, go to DONE.
//  - DONE: exactly one cycle; stall=0 so EX/MEM and MEM/WB advance; the next state is
//    unconditionally IDLE. The op still visible on the inputs in DONE is never reissued.
//  - A non-memory instruction in IDLE: stall=0; read_data holds its previous value.
//  - Latency: a 0-wait ack (ack in the first ACCESS cycle) gives 3 cycles per op:
//    IDLE, ACCESS, DONE; stall is high for 2 cycles.
//  Byte-lane rules (off = addr[1:0])
//  - Byte: be = 4'b0001<<off; wdata = {4{wd[7:0]}}.
//  - Half: be = 4'b0011<<off; wdata = {2{wd[15:0]}}.
//  - Word: be = 4'b1111; wdata = wd.
//  - Load: x = dmem_rdata >> (8*off); LB/LH sign-extend x[7:0]/x[15:0]; LBU/LHU zero-extend;
//    LW passes x unchanged.
// STRUCTURE
//  - Package mem_pkg holds:
//    - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
//    - state encoding S_IDLE=2'd0, S_ACCESS=2'd1, S_DONE=2'd2;
//    - function is_aligned(funct3, off).
//  - Sub-module load_formatter (combinational): (dmem_rdata, off, funct3) -> 32-bit result.
//  - Top level: FSM, wait counter, store lane steering, output registers.
// TESTING
//  1. SW addr 0x100, data 0xDEADBEEF, ack in 1st ACCESS cycle ->
//     dmem_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1; stall high exactly 2 cycles.
//  2. LB addr 0x103, rdata 0x80000000 -> read_data 0xFFFFFF80.
//     Repeat as LBU -> 0x00000080.
//  3. LH addr 0x102, rdata 0x8001_0000, ack after 5 waits ->
//     read_data 0xFFFF8001; stall high 7 cycles.
//  4. SH addr 0x101 -> no dmem_req, misalign_err pulse, stall=0.
//     funct3=011 with MemRead -> same response.
//  5. LW, ack withheld -> after TIMEOUT_CYCLES, bus_err pulse, read_data 0, FSM to IDLE via DONE.
//  6. rst_n low during ACCESS -> dmem_req=0 and all outputs 0 immediately.
//     An ack in the following cycle causes no state change.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Holds funct3 encodings, FSM state encoding and the alignment/legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // 1 when funct3 is a legal access width and the byte offset suits that width.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter.
// Ports:
//   dmem_rdata  in  32  raw word from data memory
//   off         in  2   byte offset within the word
//   funct3      in  3   load width / signedness
//   result      out 32  right-aligned, sign- or zero-extended load value
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] x;

  always_comb begin
    x = dmem_rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    result = {{24{x[7]}}, x[7:0]};
      F3_H:    result = {{16{x[15]}}, x[15:0]};
      F3_BU:   result = {24'd0, x[7:0]};
      F3_HU:   result = {16'd0, x[15:0]};
      default: result = x;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Issues one req/ack transaction per load/store,
// steers store lanes, formats load data and stalls the pipeline while the access is open.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ex_mem_MemRead/MemWrite        load/store present in MEM (store wins if both set)
//   ex_mem_funct3                  access width / signedness
//   ex_mem_ALU_out                 effective byte address
//   ex_mem_write_data              right-aligned store data
//   dmem_req/we/addr/be/wdata      registered request to data memory
//   dmem_ack, dmem_rdata           memory completion and read word
//   read_data                      registered formatted load result
//   stall                          freeze upstream pipeline registers
//   misalign_err, bus_err          one-cycle error pulses
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_MemRead,
  input  logic        ex_mem_MemWrite,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_ALU_out,
  input  logic [31:0] ex_mem_write_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q;
  logic [2:0]       funct3_q;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d;
  logic [31:0]      fmt_data;
  logic [1:0]       off;
  logic             op, legal, accept, reject, ack_hit, timeout;

  assign off     = ex_mem_ALU_out[1:0];
  assign op      = ex_mem_MemRead | ex_mem_MemWrite;
  assign legal   = is_aligned(ex_mem_funct3, off);
  assign accept  = (state_q == S_IDLE) && op && legal;
  assign reject  = (state_q == S_IDLE) && op && !legal;
  assign ack_hit = (state_q == S_ACCESS) && dmem_ack;
  // Abort on the edge where the wait count would reach the limit.
  assign timeout = (state_q == S_ACCESS) && !dmem_ack &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_hit || timeout) state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic; gated by rst_n so stall is low for the whole reset.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:   stall = accept;
      S_ACCESS: stall = 1'b1;
      default:  stall = 1'b0;
    endcase
    stall = stall & rst_n;
  end

  // Store lane steering
  always_comb begin
    case (ex_mem_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{ex_mem_write_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{ex_mem_write_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = ex_mem_write_data;
      end
    endcase
  end

  load_formatter u_load_formatter (
    .dmem_rdata (dmem_rdata),
    .off        (off_q),
    .funct3     (funct3_q),
    .result     (fmt_data)
  );

  // Request and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      read_data    <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= reject;
      bus_err      <= timeout;
      if (accept) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ex_mem_MemWrite;
        dmem_addr  <= {ex_mem_ALU_out[31:2], 2'b00};
        dmem_be    <= be_d;
        dmem_wdata <= wdata_d;
        off_q      <= off;
        funct3_q   <= ex_mem_funct3;
      end
      if (ack_hit || timeout) dmem_req <= 1'b0;
      if (ack_hit && !dmem_we) read_data <= fmt_data;
      if (timeout || reject) read_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out, write_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, read_data;
  logic [3:0]  dmem_be;
  logic        stall, misalign_err, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  // Results captured by run_op
  logic [31:0] cap_addr, cap_wdata, done_rd;
  logic [3:0]  cap_be;
  logic        cap_we, done_bus, done_req;
  int          stall_cycles;

  mem_access_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mem_MemRead    (mem_read),
    .ex_mem_MemWrite   (mem_write),
    .ex_mem_funct3     (funct3),
    .ex_mem_ALU_out    (alu_out),
    .ex_mem_write_data (write_data),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_be           (dmem_be),
    .dmem_wdata        (dmem_wdata),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .read_data         (read_data),
    .stall             (stall),
    .misalign_err      (misalign_err),
    .bus_err           (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an op mid-cycle in IDLE and plays memory: ack after `waits` wait cycles
  // (waits < 0 never acks). Returns in IDLE with the op removed.
  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int  wcnt = 0;
    int  cyc  = 0;
    bit  seen = 0;
    mem_read     = !wr;
    mem_write    = wr;
    funct3       = f3;
    alu_out      = addr;
    write_data   = wd;
    stall_cycles = 0;
    #1;
    while (stall && cyc < 400) begin
      stall_cycles++;
      if (dmem_req) begin
        if (!seen) begin
          cap_addr  = dmem_addr;
          cap_be    = dmem_be;
          cap_wdata = dmem_wdata;
          cap_we    = dmem_we;
          seen      = 1;
        end
        if (waits >= 0 && wcnt == waits) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rd;
        end
        wcnt++;
      end
      @(posedge clk);
      #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      cyc++;
    end
    if (cyc >= 400) check_val("stall_bound", {31'd0, stall}, 32'd0);
    // DONE cycle: op still visible, stall low
    done_rd  = read_data;
    done_bus = bus_err;
    done_req = dmem_req;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    alu_out    = 32'h0;
    write_data = 32'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    step();
    step();
    check_val("rst_req",   {31'd0, dmem_req}, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_rdata", read_data, 32'h0);
    check_val("rst_addr",  dmem_addr, 32'h0);
    check_val("rst_errs",  {30'd0, misalign_err, bus_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // SW, zero-wait
    run_op(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    check_val("sw_addr",  cap_addr, 32'h100);
    check_val("sw_be",    {28'd0, cap_be}, 32'hF);
    check_val("sw_wdata", cap_wdata, 32'hDEADBEEF);
    check_val("sw_we",    {31'd0, cap_we}, 32'd1);
    check_val("sw_stall", stall_cycles, 2);
    check_val("sw_req_done", {31'd0, done_req}, 32'd0);

    // LB / LBU at offset 3
    run_op(1'b0, F3_B, 32'h103, 32'h0, 32'h80000000, 0);
    check_val("lb_data", done_rd, 32'hFFFFFF80);
    check_val("lb_be",   {28'd0, cap_be}, 32'h8);
    check_val("lb_we",   {31'd0, cap_we}, 32'd0);
    run_op(1'b0, F3_BU, 32'h103, 32'h0, 32'h80000000, 0);
    check_val("lbu_data", done_rd, 32'h00000080);
    step();
    step();
    check_val("idle_hold", read_data, 32'h00000080);

    // LH with 5 wait cycles
    run_op(1'b0, F3_H, 32'h102, 32'h0, 32'h80010000, 5);
    check_val("lh_data",  done_rd, 32'hFFFF8001);
    check_val("lh_stall", stall_cycles, 7);
    check_val("lh_addr",  cap_addr, 32'h100);
    check_val("lh_be",    {28'd0, cap_be}, 32'hC);

    // Store lane steering
    run_op(1'b1, F3_B, 32'h102, 32'h000000A5, 32'h0, 0);
    check_val("sb_be",    {28'd0, cap_be}, 32'h4);
    check_val("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    run_op(1'b1, F3_H, 32'h102, 32'h00001234, 32'h0, 0);
    check_val("sh_be",    {28'd0, cap_be}, 32'hC);
    check_val("sh_wdata", cap_wdata, 32'h12341234);
    check_val("sh_keeps_rdata", done_rd, 32'hFFFF8001);

    // Misaligned SH, then illegal funct3
    for (int k = 0; k < 2; k++) begin
      mem_write = (k == 0);
      mem_read  = (k == 1);
      funct3    = (k == 0) ? F3_H : 3'b011;
      alu_out   = (k == 0) ? 32'h101 : 32'h100;
      #1;
      check_val("mis_stall", {31'd0, stall}, 32'd0);
      step();
      check_val("mis_err",   {31'd0, misalign_err}, 32'd1);
      check_val("mis_req",   {31'd0, dmem_req}, 32'd0);
      check_val("mis_rdata", read_data, 32'h0);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      step();
      check_val("mis_pulse", {31'd0, misalign_err}, 32'd0);
    end

    // LW then timeout
    run_op(1'b0, F3_W, 32'h200, 32'h0, 32'h12345678, 0);
    check_val("lw_data", done_rd, 32'h12345678);
    run_op(1'b0, F3_W, 32'h204, 32'h0, 32'h0, -1);
    check_val("to_stall", stall_cycles, 256);
    check_val("to_bus",   {31'd0, done_bus}, 32'd1);
    check_val("to_rdata", done_rd, 32'h0);
    check_val("to_req",   {31'd0, done_req}, 32'd0);
    check_val("to_pulse", {31'd0, bus_err}, 32'd0);

    // LHU then reset mid-access
    run_op(1'b0, F3_HU, 32'h102, 32'h0, 32'hABCD0000, 0);
    check_val("lhu_data", done_rd, 32'h0000ABCD);
    mem_write  = 1'b1;
    funct3     = F3_W;
    alu_out    = 32'h300;
    write_data = 32'h55;
    step();
    check_val("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("arst_req",   {31'd0, dmem_req}, 32'd0);
    check_val("arst_we",    {31'd0, dmem_we}, 32'd0);
    check_val("arst_addr",  dmem_addr, 32'h0);
    check_val("arst_be",    {28'd0, dmem_be}, 32'h0);
    check_val("arst_wdata", dmem_wdata, 32'h0);
    check_val("arst_rdata", read_data, 32'h0);
    check_val("arst_stall", {31'd0, stall}, 32'd0);
    step();
    mem_write  = 1'b0;
    rst_n      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    step();
    dmem_ack = 1'b0;
    check_val("late_ack_req",   {31'd0, dmem_req}, 32'd0);
    check_val("late_ack_rdata", read_data, 32'h0);
    check_val("late_ack_stall", {31'd0, stall}, 32'd0);

    // Recovery after reset
    run_op(1'b0, F3_W, 32'h10, 32'h0, 32'h0BADF00D, 1);
    check_val("recover_data",  done_rd, 32'h0BADF00D);
    check_val("recover_stall", stall_cycles, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
